// File: rtl/split_timer_core.sv
// Stopwatch core: prescaled tick drives a BCD MM:SS.CC cascade with start/pause, clear, split and
// a one-shot alarm buzzer. Define LEADING_ZERO_BLANK_EN to blank a zero leftmost digit on o4.
module split_timer_core #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned MAX_MIN     = 59,
  parameter int unsigned ALARM_MIN   = 0,
  parameter int unsigned ALARM_SEC   = 59,
  parameter int unsigned BUZZ_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       split,
  input  logic       disp_mode,
  output logic [6:0] o1,
  output logic [6:0] o2,
  output logic [6:0] o3,
  output logic [6:0] o4,
  output logic       running,
  output logic       split_active,
  output logic       buzz,
  output logic       wrapped
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned BW  = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;

  localparam logic [3:0] MaxM1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MaxM0 = 4'(MAX_MIN % 10);
  localparam logic [3:0] AlM1  = 4'(ALARM_MIN / 10);
  localparam logic [3:0] AlM0  = 4'(ALARM_MIN % 10);
  localparam logic [3:0] AlS1  = 4'(ALARM_SEC / 10);
  localparam logic [3:0] AlS0  = 4'(ALARM_SEC % 10);

  localparam logic [23:0] MaxTime   = {MaxM1, MaxM0, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam logic [23:0] AlarmTime = {AlM1, AlM0, AlS1, AlS0, 8'h00};

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] c1;
    logic [3:0] c0;
  } bcd_t;

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [BW-1:0] buzz_cnt_q;
  bcd_t          time_q, latch_q, time_next, src;
  logic          tick, at_max;
  logic [3:0]    d1, d2, d3, d4;
  logic [6:0]    seg4;

  function automatic bcd_t bcd_inc(input bcd_t t);
    bcd_t n;
    n = t;
    if (t.c0 != 4'd9) n.c0 = t.c0 + 4'd1;
    else begin
      n.c0 = 4'd0;
      if (t.c1 != 4'd9) n.c1 = t.c1 + 4'd1;
      else begin
        n.c1 = 4'd0;
        if (t.s0 != 4'd9) n.s0 = t.s0 + 4'd1;
        else begin
          n.s0 = 4'd0;
          if (t.s1 != 4'd5) n.s1 = t.s1 + 4'd1;
          else begin
            n.s1 = 4'd0;
            if (t.m0 != 4'd9) n.m0 = t.m0 + 4'd1;
            else begin
              n.m0 = 4'd0;
              n.m1 = t.m1 + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick      = (state_q == StRun) && (presc_q == PW'(DIV - 1));
  assign at_max    = time_q == MaxTime;
  // Rollover is taken only from MAX_MIN:59.99, so minutes never exceed MAX_MIN.
  assign time_next = at_max ? '0 : bcd_inc(time_q);
  assign src       = split_active ? latch_q : time_q;
  assign running   = state_q == StRun;
  assign buzz      = buzz_cnt_q != '0;

  always_comb begin
    if (disp_mode) begin
      d4 = src.s1;
      d3 = src.s0;
      d2 = src.c1;
      d1 = src.c0;
    end else begin
      d4 = src.m1;
      d3 = src.m0;
      d2 = src.s1;
      d1 = src.s0;
    end
    seg4 = seg7(d4);
`ifdef LEADING_ZERO_BLANK_EN
    if (d4 == 4'd0) seg4 = 7'b1111111;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      time_q       <= '0;
      latch_q      <= '0;
      split_active <= 1'b0;
      buzz_cnt_q   <= '0;
      wrapped      <= 1'b0;
      o1           <= 7'b1000000;
      o2           <= 7'b1000000;
      o3           <= 7'b1000000;
      o4           <= 7'b1000000;
    end else begin
      o1 <= seg7(d1);
      o2 <= seg7(d2);
      o3 <= seg7(d3);
      o4 <= seg4;
      if (clear) begin
        state_q      <= StIdle;
        presc_q      <= '0;
        time_q       <= '0;
        split_active <= 1'b0;
        buzz_cnt_q   <= '0;
        wrapped      <= 1'b0;
      end else begin
        wrapped <= tick && at_max;
        // Prescaler holds in PAUSE so a resume keeps the sub-tick phase.
        if (state_q == StRun) presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) time_q <= time_next;
        if (tick && (time_next == AlarmTime)) buzz_cnt_q <= BW'(BUZZ_CYCLES);
        else if (buzz_cnt_q != '0)             buzz_cnt_q <= buzz_cnt_q - 1'b1;
        if (start_stop) begin
          unique case (state_q)
            StIdle: begin
              state_q <= StRun;
              presc_q <= '0;
            end
            StRun:   state_q <= StPause;
            default: state_q <= StRun;
          endcase
        end else if (split && (state_q != StIdle)) begin
          if (!split_active) latch_q <= time_q;
          split_active <= !split_active;
        end
      end
    end
  end

endmodule
